uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Parametrised UART transmitter: the next-generation serializer for the demodulator's debug/sample output path. Accepts words over a valid/ready handshake into a small internal FIFO, then emits them LSB-first with configurable baud divisor, data width, parity and stop bits. Back-to-back frames leave no idle gap on the line.

## Interface
- CLKS_PER_BIT, 2: clock cycles per line bit, ≥1.
- DATA_W, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: words buffered, power of two, ≥2.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_i  in  DATA_W  word to send.
- valid_i  in  1  data_i valid.
- ready_o  out  1  FIFO can accept; transfer on rising edge with valid_i && ready_o.
- uart_o  out  1  serial line, idle high, registered.
- busy_o  out  1  frame in progress or FIFO non-empty.
- level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values: uart_o=1, ready_o=1, busy_o=0, level_o=0; FSM IDLE; FIFO empty. Reset asserted mid-frame truncates the frame: uart_o returns high asynchronously, buffered words are discarded.
- ready_o = !full, derived from registered count only; no combinational path from valid_i.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if FIFO non-empty, pop the head into the shift register, uart_o<=0, go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out DATA_W bits LSB-first, each for CLKS_PER_BIT cycles. Then go to PAR if PARITY≠0, else STOP.
  - PAR: drive the parity bit. Even = XOR of data bits; odd = its inverse.
  - STOP: drive 1 for STOP_BITS×CLKS_PER_BIT cycles.
  - On the last cycle of STOP: if FIFO non-empty, pop and go to START with no gap. Otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 with width $clog2(CLKS_PER_BIT+1). A separate bit counter tracks the bit index.
- Push and pop in the same cycle leave the count unchanged.
- A push while full cannot occur, because ready_o=0.
- valid_i while ready_o=0 is ignored; data_i must be held by the source.
- busy_o = (state≠IDLE) || (level≠0).

## Timing
- Frame length: CLKS_PER_BIT×(1+DATA_W+(PARITY≠0)+STOP_BITS) cycles exactly.
- Latency from idle: word accepted at edge N, FIFO count 1 after N; uart_o falls at edge N+1.
- level_o updates on the edge after push/pop.
- Back-to-back: the next start bit begins on the cycle immediately following the final stop-bit cycle.

## Structure
- Package uart_pkg: parity mode constants (PAR_NONE/EVEN/ODD) and the FSM state enum for tx.
- Sub-module uart_tx_fifo: synchronous FIFO (DEPTH, W params; push, pop, full, empty, count) with async active-low reset. The FSM, shift register and counters stay in the top.
- Elaboration check rejects out-of-range DATA_W, STOP_BITS, PARITY and non-power-of-two FIFO_DEPTH.

## Test plan
- Basic frame (CLKS_PER_BIT=4, 8N1): send 0xA5 -> 4 low, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then 4 high; 40 cycles total; busy_o falls after.
- Parity (CLKS_PER_BIT=4, 8E1 then 8O1): send 0x07 -> parity bit 1 (even), 0 (odd); frame 44 cycles.
- Back-to-back (8N2, CLKS_PER_BIT=4): push 0x55, 0xAA consecutively -> second start edge exactly 44 cycles after first; line never idles between frames.
- Backpressure (FIFO_DEPTH=4): valid_i held high with 6 words from idle -> 5 accepted, ready_o low from 6th cycle, level_o=4. ready_o rises one cycle after the second frame's start pop; no word lost or duplicated.
- Width/divisor (DATA_W=5, CLKS_PER_BIT=1, 5N1): send 0x1F -> 0,1,1,1,1,1,1 on consecutive cycles; 7-cycle frame.
- Reset mid-frame: rst_n low during data bit 3 with 2 words queued -> uart_o=1 immediately, level_o=0, ready_o=1. After release, the next pushed word transmits a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmitter: parity mode codes and the
//   transmit FSM state encoding.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      TX_IDLE  = 3'd0,
      TX_START = 3'd1,
      TX_DATA  = 3'd2,
      TX_PAR   = 3'd3,
      TX_STOP  = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Synchronous first-word-fall-through FIFO buffering words ahead of the
//   serializer. rdata always shows the head word while empty is low.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  write request and word; ignored while full
//   pop, rdata   read request and head word; pop ignored while empty
//   full, empty  occupancy flags derived from the registered count
//   count        current occupancy, 0..DEPTH
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage is not reset: contents are only visible once count says so.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
//   Parametrised UART transmitter. Words enter a small FIFO over a
//   valid/ready handshake and leave LSB-first as start / data / optional
//   parity / stop bits. Consecutive frames are emitted with no idle gap.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset; truncates any frame in flight
//   data_i     word to send (DATA_W bits)
//   valid_i    data_i valid
//   ready_o    FIFO not full; a word transfers on valid_i && ready_o
//   uart_o     registered serial line, idle high
//   busy_o     frame in progress or FIFO non-empty
//   level_o    FIFO occupancy
//
// state    | meaning
// ---------+-----------------------------------------------------------
// TX_IDLE  | line high, waiting for a buffered word
// TX_START | start bit (0) on the line for CLKS_PER_BIT cycles
// TX_DATA  | data bits LSB-first, bit_q is the index of the bit on line
// TX_PAR   | parity bit (only reached when PARITY != PAR_NONE)
// TX_STOP  | stop bit(s) (1), bit_q counts stop bits; may chain to START
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 2,
   parameter int DATA_W       = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_W-1:0]             data_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   output logic                          uart_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o
);

   localparam int BW   = $clog2(CLKS_PER_BIT + 1);
   localparam int BITW = $clog2(DATA_W);

   localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BITW-1:0] BIT_LAST  = BITW'(DATA_W - 1);
   localparam logic [BITW-1:0] STOP_LAST = BITW'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 1) begin : g_bad_cpb
      $error("uart_tx_cfg: CLKS_PER_BIT must be at least 1");
   end
   if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
      $error("uart_tx_cfg: DATA_W must be in 5..9");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_cfg: FIFO_DEPTH must be a power of two, at least 2");
   end

   tx_state_e           state_q, state_nx;
   logic [BW-1:0]       baud_q, baud_nx;
   logic [BITW-1:0]     bit_q, bit_nx;
   logic [DATA_W-1:0]   shift_q, shift_nx;
   logic                par_q, par_nx;
   logic                uart_q, uart_nx;

   logic                fifo_push;
   logic                fifo_pop;
   logic [DATA_W-1:0]   fifo_rdata;
   logic                fifo_full;
   logic                fifo_empty;
   logic                baud_end;
   logic                load_par;

   assign fifo_push = valid_i && !fifo_full;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (data_i),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (level_o)
   );

   assign baud_end = (baud_q == BAUD_LAST);

   // Parity is computed once when the word is loaded, before shifting
   // destroys the data.
   assign load_par = (^fifo_rdata) ^ (PARITY == PAR_ODD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         uart_q  <= 1'b1;
      end else begin
         state_q <= state_nx;
         baud_q  <= baud_nx;
         bit_q   <= bit_nx;
         shift_q <= shift_nx;
         par_q   <= par_nx;
         uart_q  <= uart_nx;
      end
   end

   // uart_nx is the line value for the cycle after this edge, so every
   // bit boundary loads the next bit one edge ahead of its first cycle.
   always_comb begin
      state_nx = state_q;
      baud_nx  = baud_q;
      bit_nx   = bit_q;
      shift_nx = shift_q;
      par_nx   = par_q;
      uart_nx  = uart_q;
      fifo_pop = 1'b0;

      case (state_q)
         TX_IDLE: begin
            uart_nx = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_nx = fifo_rdata;
               par_nx   = load_par;
               uart_nx  = 1'b0;
               baud_nx  = '0;
               bit_nx   = '0;
               state_nx = TX_START;
            end
         end

         TX_START: begin
            if (baud_end) begin
               baud_nx  = '0;
               bit_nx   = '0;
               uart_nx  = shift_q[0];
               state_nx = TX_DATA;
            end else begin
               baud_nx = baud_q + 1'b1;
            end
         end

         TX_DATA: begin
            if (baud_end) begin
               baud_nx = '0;
               if (bit_q == BIT_LAST) begin
                  bit_nx = '0;
                  if (PARITY != PAR_NONE) begin
                     uart_nx  = par_q;
                     state_nx = TX_PAR;
                  end else begin
                     uart_nx  = 1'b1;
                     state_nx = TX_STOP;
                  end
               end else begin
                  bit_nx   = bit_q + 1'b1;
                  shift_nx = shift_q >> 1;
                  uart_nx  = shift_q[1];
               end
            end else begin
               baud_nx = baud_q + 1'b1;
            end
         end

         TX_PAR: begin
            if (baud_end) begin
               baud_nx  = '0;
               bit_nx   = '0;
               uart_nx  = 1'b1;
               state_nx = TX_STOP;
            end else begin
               baud_nx = baud_q + 1'b1;
            end
         end

         TX_STOP: begin
            if (baud_end) begin
               baud_nx = '0;
               if (bit_q == STOP_LAST) begin
                  bit_nx = '0;
                  // Chain straight into the next start bit when a word waits.
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     shift_nx = fifo_rdata;
                     par_nx   = load_par;
                     uart_nx  = 1'b0;
                     state_nx = TX_START;
                  end else begin
                     uart_nx  = 1'b1;
                     state_nx = TX_IDLE;
                  end
               end else begin
                  bit_nx = bit_q + 1'b1;
               end
            end else begin
               baud_nx = baud_q + 1'b1;
            end
         end

         default: begin
            uart_nx  = 1'b1;
            state_nx = TX_IDLE;
         end
      endcase
   end

   assign uart_o  = uart_q;
   assign ready_o = !fifo_full;
   assign busy_o  = (state_q != TX_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg. Four instances cover 8E1, 8N2, 5N1 (one clock
// per bit) and 9O2 with a deeper FIFO. A frame-level reference model builds
// the expected line waveform of each word from the framing rules and checks
// every output of every instance on every cycle.
module tb_uart_tx_cfg;

   localparam int NI = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [8:0] drv_data  [NI];
   logic       drv_valid [NI];
   logic       uart_w    [NI];
   logic       busy_w    [NI];
   logic       ready_w   [NI];
   logic [2:0] lvl0;
   logic [2:0] lvl1;
   logic [1:0] lvl2;
   logic [3:0] lvl3;

   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .data_i(drv_data[0][7:0]), .valid_i(drv_valid[0]),
      .ready_o(ready_w[0]), .uart_o(uart_w[0]), .busy_o(busy_w[0]), .level_o(lvl0));
   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .data_i(drv_data[1][7:0]), .valid_i(drv_valid[1]),
      .ready_o(ready_w[1]), .uart_o(uart_w[1]), .busy_o(busy_w[1]), .level_o(lvl1));
   uart_tx_cfg #(.CLKS_PER_BIT(1), .DATA_W(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .data_i(drv_data[2][4:0]), .valid_i(drv_valid[2]),
      .ready_o(ready_w[2]), .uart_o(uart_w[2]), .busy_o(busy_w[2]), .level_o(lvl2));
   uart_tx_cfg #(.CLKS_PER_BIT(3), .DATA_W(9), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .data_i(drv_data[3]), .valid_i(drv_valid[3]),
      .ready_o(ready_w[3]), .uart_o(uart_w[3]), .busy_o(busy_w[3]), .level_o(lvl3));

   int cpb_c [NI];
   int dw_c  [NI];
   int par_c [NI];
   int sb_c  [NI];
   int dep_c [NI];

   // reference model: word queue plus the bit sequence of the frame on the line
   logic [8:0] mq_mem  [NI][16];
   int         mq_head [NI];
   int         mq_cnt  [NI];
   logic       frame_b [NI][64];
   int         flen    [NI];
   int         fpos    [NI];
   logic       e_uart  [NI];
   logic       e_busy  [NI];
   logic       e_ready [NI];
   int         e_level [NI];
   logic       acc_q   [NI];

   logic       s_uart  [NI];
   logic       s_busy  [NI];
   logic       s_ready [NI];
   int         s_level [NI];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         k;
      logic [8:0] data;
      int         exp_len;
      int         exp_par;
   } vec_t;
   vec_t vecs [6];

   function automatic int dut_level(input int k);
      case (k)
         0:       return int'(lvl0);
         1:       return int'(lvl1);
         2:       return int'(lvl2);
         default: return int'(lvl3);
      endcase
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", name, k, cyc, act, exp);
      end
   endtask

   task automatic build_frame(input int k, input logic [8:0] w);
      int   n;
      logic p;
      n = 0;
      p = 1'b0;
      for (int r = 0; r < cpb_c[k]; r++) begin frame_b[k][n] = 1'b0; n++; end
      for (int i = 0; i < dw_c[k]; i++) begin
         p = p ^ w[i];
         for (int r = 0; r < cpb_c[k]; r++) begin frame_b[k][n] = w[i]; n++; end
      end
      if (par_c[k] != 0) begin
         if (par_c[k] == 2) p = !p;
         for (int r = 0; r < cpb_c[k]; r++) begin frame_b[k][n] = p; n++; end
      end
      for (int r = 0; r < sb_c[k] * cpb_c[k]; r++) begin frame_b[k][n] = 1'b1; n++; end
      flen[k] = n;
      fpos[k] = 0;
   endtask

   // Advance the model across one rising edge, using pre-edge state.
   task automatic model_step(input int k, output logic acc);
      logic [8:0] w;
      logic       emitted;
      acc     = drv_valid[k] && (mq_cnt[k] < dep_c[k]);
      emitted = 1'b0;
      if (fpos[k] == flen[k] && mq_cnt[k] > 0) begin
         w          = mq_mem[k][mq_head[k]];
         mq_head[k] = (mq_head[k] + 1) % 16;
         mq_cnt[k]  = mq_cnt[k] - 1;
         build_frame(k, w);
      end
      if (fpos[k] < flen[k]) begin
         e_uart[k] = frame_b[k][fpos[k]];
         fpos[k]   = fpos[k] + 1;
         emitted   = 1'b1;
      end else begin
         e_uart[k] = 1'b1;
      end
      if (acc) begin
         mq_mem[k][(mq_head[k] + mq_cnt[k]) % 16] = drv_data[k];
         mq_cnt[k] = mq_cnt[k] + 1;
      end
      e_level[k] = mq_cnt[k];
      e_ready[k] = (mq_cnt[k] < dep_c[k]);
      e_busy[k]  = emitted || (mq_cnt[k] > 0);
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         mq_head[k] = 0; mq_cnt[k] = 0; flen[k] = 0; fpos[k] = 0;
         e_uart[k] = 1'b1; e_busy[k] = 1'b0; e_ready[k] = 1'b1; e_level[k] = 0;
         acc_q[k] = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      for (int k = 0; k < NI; k++) begin
         logic a;
         model_step(k, a);
         acc_q[k] = a;
      end
      #1;
      cyc++;
      for (int k = 0; k < NI; k++) begin
         s_uart[k]  = uart_w[k];
         s_busy[k]  = busy_w[k];
         s_ready[k] = ready_w[k];
         s_level[k] = dut_level(k);
         chk("uart",  k, 32'(s_uart[k]),  32'(e_uart[k]));
         chk("busy",  k, 32'(s_busy[k]),  32'(e_busy[k]));
         chk("ready", k, 32'(s_ready[k]), 32'(e_ready[k]));
         chk("level", k, s_level[k],      e_level[k]);
      end
   endtask

   task automatic wait_idle(input int max);
      bit idle;
      for (int i = 0; i <= max; i++) begin
         idle = 1'b1;
         for (int k = 0; k < NI; k++) if (e_busy[k]) idle = 1'b0;
         if (idle) break;
         if (i < max) step();
      end
      if (!idle) chk("wait_idle_timeout", 0, 32'(idle), 32'd1);
   endtask

   task automatic push_word(input int k, input logic [8:0] w, input int max);
      logic ok;
      ok = 1'b0;
      drv_valid[k] = 1'b1;
      drv_data[k]  = w;
      for (int i = 0; i < max; i++) begin
         step();
         if (acc_q[k]) begin ok = 1'b1; break; end
      end
      drv_valid[k] = 1'b0;
      chk("push_accept", k, 32'(ok), 32'd1);
   endtask

   task automatic send_and_measure(input string name, input int k, input logic [8:0] w,
                                   input int exp_len, input int exp_par);
      int start;
      int len;
      int par;
      wait_idle(400);
      push_word(k, w, 50);
      start = -1;
      len   = 0;
      par   = -1;
      for (int i = 0; i < 300; i++) begin
         step();
         if (start < 0 && s_uart[k] == 1'b0) start = cyc;
         if (start >= 0) begin
            if (!s_busy[k]) break;
            len++;
            if (cyc - start == cpb_c[k] * (1 + dw_c[k]) + cpb_c[k] / 2) par = int'(s_uart[k]);
         end
      end
      chk({name, "_len"}, k, len, exp_len);
      if (exp_par >= 0) chk({name, "_par"}, k, par, exp_par);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_start;
      int busy_low;
      int wi;
      int rise;
      int s;
      logic [8:0] words [6];

      cpb_c = '{4, 4, 1, 3};
      dw_c  = '{8, 8, 5, 9};
      par_c = '{1, 0, 0, 2};
      sb_c  = '{1, 2, 1, 2};
      dep_c = '{4, 4, 2, 8};

      vecs[0] = '{0, 9'h0A5, 44, 0};
      vecs[1] = '{0, 9'h007, 44, 1};
      vecs[2] = '{1, 9'h0A5, 44, -1};
      vecs[3] = '{2, 9'h01F, 7, -1};
      vecs[4] = '{3, 9'h007, 39, 0};
      vecs[5] = '{3, 9'h003, 39, 1};

      for (int k = 0; k < NI; k++) begin
         drv_valid[k] = 1'b0;
         drv_data[k]  = '0;
      end
      model_reset();

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("rst_uart",  k, 32'(uart_w[k]),  32'd1);
         chk("rst_ready", k, 32'(ready_w[k]), 32'd1);
         chk("rst_busy",  k, 32'(busy_w[k]),  32'd0);
         chk("rst_level", k, dut_level(k),    0);
      end
      rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         send_and_measure("frame", vecs[v].k, vecs[v].data, vecs[v].exp_len, vecs[v].exp_par);
      end

      // back-to-back on 8N2, 4 clocks per bit
      wait_idle(400);
      drv_valid[1] = 1'b1;
      drv_data[1]  = 9'h055;
      step();
      drv_data[1]  = 9'h0AA;
      step();
      drv_valid[1] = 1'b0;
      first_start  = cyc;
      chk("b2b_first_start", 1, 32'(s_uart[1]), 32'd0);
      busy_low = 0;
      for (int i = 0; i < 44; i++) begin
         step();
         if (!s_busy[1]) busy_low++;
         if (cyc == first_start + 43) chk("b2b_last_stop", 1, 32'(s_uart[1]), 32'd1);
         if (cyc == first_start + 44) chk("b2b_second_start", 1, 32'(s_uart[1]), 32'd0);
      end
      chk("b2b_no_idle", 1, busy_low, 0);
      wait_idle(400);

      // backpressure: six words offered back to back on the depth-4 instance
      words = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};
      wi = 0;
      first_start = -1;
      drv_valid[0] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         drv_data[0] = words[wi];
         step();
         if (acc_q[0]) wi++;
         if (first_start < 0 && s_uart[0] == 1'b0) first_start = cyc;
      end
      chk("bp_accepted", 0, wi, 5);
      chk("bp_ready_low", 0, 32'(s_ready[0]), 32'd0);
      chk("bp_level", 0, s_level[0], 4);
      rise = -1;
      for (int i = 0; i < 200 && wi < 6; i++) begin
         drv_data[0] = words[wi];
         step();
         if (rise < 0 && s_ready[0]) rise = cyc;
         if (acc_q[0]) wi++;
      end
      drv_valid[0] = 1'b0;
      chk("bp_ready_rise", 0, rise, first_start + 44);
      chk("bp_all_accepted", 0, wi, 6);
      wait_idle(600);

      // randomized traffic on all instances, sparse then dense
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NI; k++) begin
            if (!drv_valid[k] || acc_q[k]) begin
               drv_valid[k] = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
               drv_data[k]  = 9'($urandom);
            end
         end
         step();
      end
      for (int k = 0; k < NI; k++) drv_valid[k] = 1'b0;
      wait_idle(2000);

      // reset during data bit 3 with two words queued
      push_word(0, 9'h0F0, 20);
      push_word(0, 9'h0C3, 20);
      s = cyc;
      push_word(0, 9'h05A, 20);
      for (int i = 0; i < 50; i++) begin
         if (cyc >= s + 17) break;
         step();
      end
      chk("mid_queued", 0, s_level[0], 2);
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NI; k++) begin
         chk("mid_rst_uart",  k, 32'(uart_w[k]),  32'd1);
         chk("mid_rst_ready", k, 32'(ready_w[k]), 32'd1);
         chk("mid_rst_busy",  k, 32'(busy_w[k]),  32'd0);
         chk("mid_rst_level", k, dut_level(k),    0);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      send_and_measure("post_rst", 0, 9'h03C, 44, 0);
      wait_idle(400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
